// File: rtl/jacobi_pivot_prep.sv
// Jacobi pivot preparation: reads a_pp, a_qq, a_pq per upper-triangle pair and emits saturated
// x = a_qq - a_pp, y = 2*a_pq for the angle pipeline. Optional skip: define JACOBI_PIVOT_SKIP_EN.
package common;
    localparam int JACOBI_OUTPUT_WORD_WIDTH = 16;
endpackage

module jacobi_pivot_prep
    import common::*;
#(
    parameter  int N           = 4,
    parameter  int SKIP_THRESH = 0,
    localparam int W           = JACOBI_OUTPUT_WORD_WIDTH,
    localparam int AW          = $clog2(N*N),
    localparam int PW          = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    output logic                rd_en_o,
    output logic [AW-1:0]       rd_addr_o,
    input  logic signed [W-1:0] rd_data_i,
    output logic signed [W-1:0] x_o,
    output logic signed [W-1:0] y_o,
    output logic                vld_o,
    output logic [PW-1:0]       p_o,
    output logic [PW-1:0]       q_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [15:0]         skip_cnt_o
);

`ifdef JACOBI_PIVOT_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RD_PP, RD_QQ, RD_PQ, CALC} state_t;

    state_t              r_state;
    logic [PW-1:0]       r_p, r_q;
    logic signed [W-1:0] r_app, r_aqq;
    logic [15:0]         r_skip_cnt;

    logic                w_q_wrap, w_last, w_hit, w_skip;
    logic [PW-1:0]       w_np, w_nq;
    logic signed [W:0]   w_dx, w_dy;
    logic [W:0]          w_abs_pq;

    function automatic logic [AW-1:0] f_addr(input logic [PW-1:0] r, input logic [PW-1:0] c);
        int a;
        a = int'(r) * N + int'(c);
        return AW'(a);
    endfunction

    function automatic logic signed [W-1:0] f_sat(input logic signed [W:0] v);
        if (v[W] != v[W-1])
            return v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return v[W-1:0];
    endfunction

    // next pair in row-major upper-triangle order
    assign w_q_wrap = (r_q == PW'(N-1));
    assign w_last   = w_q_wrap && (r_p == PW'(N-2));
    assign w_np     = w_q_wrap ? PW'(r_p + PW'(1)) : r_p;
    assign w_nq     = w_q_wrap ? PW'(r_p + PW'(2)) : PW'(r_q + PW'(1));

    // W+1-bit arithmetic keeps the true result so saturation never sees a wrapped value
    assign w_dx     = {r_aqq[W-1], r_aqq} - {r_app[W-1], r_app};
    assign w_dy     = {rd_data_i, 1'b0};
    assign w_abs_pq = rd_data_i[W-1] ? (W+1)'(-{rd_data_i[W-1], rd_data_i})
                                     : {1'b0, rd_data_i};
    assign w_hit    = (32'(w_abs_pq) <= 32'(SKIP_THRESH));
    assign w_skip   = SKIP_EN && w_hit;

    assign skip_cnt_o = SKIP_EN ? r_skip_cnt : 16'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_p        <= '0;
            r_q        <= '0;
            r_app      <= '0;
            r_aqq      <= '0;
            r_skip_cnt <= '0;
            rd_en_o    <= 1'b0;
            rd_addr_o  <= '0;
            x_o        <= '0;
            y_o        <= '0;
            p_o        <= '0;
            q_o        <= '0;
            vld_o      <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            vld_o   <= 1'b0;
            done_o  <= 1'b0;
            rd_en_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state    <= RD_PP;
                        r_p        <= '0;
                        r_q        <= PW'(1);
                        r_skip_cnt <= '0;
                        rd_en_o    <= 1'b1;
                        rd_addr_o  <= f_addr('0, '0);
                        busy_o     <= 1'b1;
                    end
                end
                RD_PP: begin
                    r_state   <= RD_QQ;
                    rd_en_o   <= 1'b1;
                    rd_addr_o <= f_addr(r_q, r_q);
                end
                RD_QQ: begin
                    r_app     <= rd_data_i;
                    r_state   <= RD_PQ;
                    rd_en_o   <= 1'b1;
                    rd_addr_o <= f_addr(r_p, r_q);
                end
                RD_PQ: begin
                    r_aqq   <= rd_data_i;
                    r_state <= CALC;
                end
                CALC: begin
                    // a_pq arrives this cycle and is consumed without a register stage
                    if (!w_skip) begin
                        vld_o <= 1'b1;
                        x_o   <= f_sat(w_dx);
                        y_o   <= f_sat(w_dy);
                        p_o   <= r_p;
                        q_o   <= r_q;
                    end else if (r_skip_cnt != 16'hFFFF) begin
                        r_skip_cnt <= r_skip_cnt + 16'd1;
                    end
                    if (w_last) begin
                        r_state <= IDLE;
                        r_p     <= '0;
                        r_q     <= '0;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                    end else begin
                        r_state   <= RD_PP;
                        r_p       <= w_np;
                        r_q       <= w_nq;
                        rd_en_o   <= 1'b1;
                        rd_addr_o <= f_addr(w_np, w_np);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jacobi_pivot_prep.sv
// Directed bench for jacobi_pivot_prep (N=3, W=16, SKIP_THRESH=4) with a 1-cycle-latency RAM model.
module tb_jacobi_pivot_prep;

    localparam int NS = 20;
`ifdef JACOBI_PIVOT_SKIP_EN
    localparam bit SK = 1'b1;
`else
    localparam bit SK = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_i = 1'b0;
    logic               rd_en_o;
    logic [3:0]         rd_addr_o;
    logic signed [15:0] rd_data_i = '0;
    logic signed [15:0] x_o, y_o;
    logic               vld_o, busy_o, done_o;
    logic [1:0]         p_o, q_o;
    logic [15:0]        skip_cnt_o;

    int tests = 0;
    int fails = 0;

    logic signed [15:0] mem [0:8];

    logic               lv [0:NS], ld [0:NS], lb [0:NS], lre [0:NS];
    logic signed [15:0] lx [0:NS], ly [0:NS];
    logic [1:0]         lp [0:NS], lq [0:NS];
    logic [3:0]         la [0:NS];
    logic [15:0]        lsk [0:NS];

    jacobi_pivot_prep #(.N(3), .SKIP_THRESH(4)) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .x_o(x_o), .y_o(y_o), .vld_o(vld_o), .p_o(p_o), .q_o(q_o),
        .busy_o(busy_o), .done_o(done_o), .skip_cnt_o(skip_cnt_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en_o) rd_data_i <= mem[rd_addr_o];

    task automatic chk(input string tag, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vld"}, longint'(vld_o), 0);
        chk({tag, "_done"}, longint'(done_o), 0);
        chk({tag, "_busy"}, longint'(busy_o), 0);
        chk({tag, "_rden"}, longint'(rd_en_o), 0);
        chk({tag, "_addr"}, longint'(rd_addr_o), 0);
        chk({tag, "_x"}, longint'(x_o), 0);
        chk({tag, "_y"}, longint'(y_o), 0);
        chk({tag, "_p"}, longint'(p_o), 0);
        chk({tag, "_q"}, longint'(q_o), 0);
        chk({tag, "_skip"}, longint'(skip_cnt_o), 0);
    endtask

    task automatic load(input logic signed [15:0] a00, a11, a22, a01, a02, a12);
        mem[0] = a00; mem[4] = a11; mem[8] = a22;
        mem[1] = a01; mem[3] = a01;
        mem[2] = a02; mem[6] = a02;
        mem[5] = a12; mem[7] = a12;
    endtask

    // Sample k is taken at the negedge after the k-th posedge following the start pulse.
    // xs: sample after which start_i is re-pulsed; ra: sample after which rst is pulsed.
    task automatic sweep(input int xs, input int ra);
        @(negedge clk);
        start_i = 1'b1;
        for (int k = 1; k <= NS; k++) begin
            @(negedge clk);
            lv[k] = vld_o;   ld[k] = done_o; lb[k] = busy_o; lre[k] = rd_en_o;
            lx[k] = x_o;     ly[k] = y_o;    lp[k] = p_o;    lq[k] = q_o;
            la[k] = rd_addr_o; lsk[k] = skip_cnt_o;
            start_i = (k == xs);
            if (k == ra) begin
                rst = 1'b1;
                #1;
                chk_zero("rst_mid");
            end else begin
                rst = 1'b0;
            end
        end
    endtask

    function automatic int n_vld();
        int n = 0;
        for (int k = 1; k <= NS; k++) if (lv[k]) n++;
        return n;
    endfunction

    function automatic int n_done();
        int n = 0;
        for (int k = 1; k <= NS; k++) if (ld[k]) n++;
        return n;
    endfunction

    initial begin
        int ex_x [3] = '{200, -150, -350};
        int ex_y [3] = '{100, 6, -14};
        int ex_p [3] = '{0, 0, 1};
        int ex_q [3] = '{1, 2, 2};
        int ex_t [3] = '{5, 9, 13};
        int ex_a [9] = '{0, 4, 1, 0, 8, 2, 4, 8, 5};
        int na;

        load(100, 300, -50, 50, 3, -7);
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // full sweep: order, spacing, latency, done/busy alignment, address trace
        sweep(0, 0);
        chk("lat_no_early", longint'(lv[4]), 0);
        for (int i = 0; i < 3; i++) begin
            if (SK && i == 1) begin
                chk("skip_no_vld", longint'(lv[ex_t[i]]), 0);
            end else begin
                chk($sformatf("em%0d_vld", i), longint'(lv[ex_t[i]]), 1);
                chk($sformatf("em%0d_x", i), longint'(lx[ex_t[i]]), ex_x[i]);
                chk($sformatf("em%0d_y", i), longint'(ly[ex_t[i]]), ex_y[i]);
                chk($sformatf("em%0d_p", i), longint'(lp[ex_t[i]]), ex_p[i]);
                chk($sformatf("em%0d_q", i), longint'(lq[ex_t[i]]), ex_q[i]);
            end
        end
        chk("hold_x", longint'(lx[14]), -350);
        chk("n_vld", n_vld(), SK ? 2 : 3);
        chk("done_at", longint'(ld[13]), 1);
        chk("n_done", n_done(), 1);
        chk("busy_pre", longint'(lb[12]), 1);
        chk("busy_fall", longint'(lb[13]), 0);
        chk("skip_cnt", longint'(lsk[NS]), SK ? 1 : 0);
        na = 0;
        for (int k = 1; k <= NS; k++) begin
            if (lre[k]) begin
                if (na < 9) chk($sformatf("addr%0d", na), longint'(la[k]), ex_a[na]);
                na++;
            end
        end
        chk("n_reads", na, 9);

        // saturation on both outputs
        load(-32768, 32767, 0, -20000, 100, 100);
        sweep(0, 0);
        chk("sat_vld", longint'(lv[5]), 1);
        chk("sat_x", longint'(lx[5]), 32767);
        chk("sat_y", longint'(ly[5]), -32768);

        // reset just after the 2nd emission, then restart from (0,1)
        load(100, 300, -50, 50, 30, -7);
        sweep(0, 9);
        chk("rst_n_vld", n_vld(), 2);
        chk("rst_n_done", n_done(), 0);
        chk("rst_busy", longint'(lb[NS]), 0);
        sweep(0, 0);
        chk("rst_re_vld", longint'(lv[5]), 1);
        chk("rst_re_p", longint'(lp[5]), 0);
        chk("rst_re_q", longint'(lq[5]), 1);
        chk("rst_re_x", longint'(lx[5]), 200);

        // a second start mid-sweep is ignored
        load(100, 300, -50, 50, 3, -7);
        sweep(2, 0);
        chk("restart_n_vld", n_vld(), SK ? 2 : 3);
        chk("restart_n_done", n_done(), 1);
        chk("restart_done_at", longint'(ld[13]), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jacobi_pivot_prep.md
JACOBI_PIVOT_PREP -- requirements
Module: jacobi_pivot_prep

Interface
REQ-001 The block SHALL import common:: and define W = JACOBI_OUTPUT_WORD_WIDTH; all data ports SHALL be signed W bits.
REQ-002 Parameter N, default 4, meaning matrix dimension; legal range N >= 2.
REQ-003 Parameter SKIP_THRESH, default 0, meaning the unsigned skip threshold on |a_pq|; it is used only under REQ-026.
REQ-004 Derived parameter AW = $clog2(N*N), meaning the address width.
REQ-005 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port start_i, input, 1 bit: starts one sweep.
REQ-008 Port rd_en_o, output, 1 bit: matrix RAM read strobe.
REQ-009 Port rd_addr_o, output, AW bits: read address, row*N + col.
REQ-010 Port rd_data_i, input, W bits: RAM data, valid exactly 1 cycle after rd_en_o.
REQ-011 Ports x_o and y_o, outputs, W bits each: x = a_qq - a_pp and y = 2*a_pq, saturated; they feed calc_angle_pipeline x_i/y_i.
REQ-012 Port vld_o, output, 1 bit: x_o/y_o valid for 1 cycle; there is no backpressure.
REQ-013 Ports p_o and q_o, outputs, $clog2(N) bits each: the pivot indices tagged to the emission.
REQ-014 Ports busy_o, output, 1 bit, and done_o, output, 1 bit: busy_o is high during a sweep; done_o is a 1-cycle end-of-sweep pulse.
REQ-015 Port skip_cnt_o, output, 16 bits: the number of pairs skipped in the current or last sweep.

Function
REQ-016 The FSM SHALL have the states IDLE, RD_PP, RD_QQ, RD_PQ and CALC.
REQ-017 In IDLE, start_i=1 SHALL select IDLE->RD_PP with p=0, q=1 and SHALL clear skip_cnt_o.
- start_i outside IDLE is ignored.
REQ-018 The read states SHALL each assert rd_en_o for 1 cycle with these addresses:
- RD_PP: p*N+p.
- RD_QQ: q*N+q.
- RD_PQ: p*N+q.
- rd_en_o=0 in IDLE and CALC.
REQ-019 The block SHALL capture rd_data_i as follows:
- a_pp on the clock edge leaving RD_QQ.
- a_qq on the edge leaving RD_PQ.
- a_pq is used directly on the edge leaving CALC.
REQ-020 On the edge leaving CALC, the block SHALL register x_o, y_o, p_o and q_o and set vld_o=1 for the following cycle.
- Emissions are spaced exactly 4 cycles apart.
- Latency from start_i to the first vld_o is 5 cycles.
REQ-021 Pair order SHALL be row-major upper triangle: p=0..N-2, q=p+1..N-1, giving N(N-1)/2 pairs per sweep.
REQ-022 After CALC, the FSM SHALL advance as follows:
- Go to RD_PP with the next pair.
- After the last pair, go to IDLE.
- done_o=1 in the cycle after the last CALC, coincident with the final vld_o.
REQ-023 Arithmetic SHALL be done in W+1 bits and then saturated to [-2^(W-1), 2^(W-1)-1]; there is no wrap-around.
REQ-024 busy_o SHALL be 1 in every state except IDLE; x_o, y_o, p_o and q_o SHALL hold their last values while vld_o=0.

Reset
REQ-025 While rst=1, at any time including mid-sweep, the block SHALL force:
- state=IDLE, with the p/q counters at 0.
- x_o, y_o, p_o, q_o and skip_cnt_o at 0.
- vld_o, done_o, busy_o and rd_en_o at 0.
- rd_addr_o at 0.
After reset the next start_i SHALL begin at pair (0,1).

Configuration
REQ-026 With macro JACOBI_PIVOT_SKIP_EN defined, a pair with |a_pq| <= SKIP_THRESH in CALC SHALL:
- produce no vld_o;
- increment skip_cnt_o, saturating at 16'hFFFF;
- keep the sweep timing unchanged, with done_o still pulsing at the REQ-022 cycle.
REQ-027 Without JACOBI_PIVOT_SKIP_EN, every pair SHALL be emitted and skip_cnt_o SHALL be tied to 0.

Verification
REQ-028 Use W=16, N=3. Load a_00=100, a_11=300, a_01=50 and start -> first vld_o 5 cycles after start with x_o=200, y_o=100, p_o=0, q_o=1.
REQ-029 Load a_11=32767, a_00=-32768, a_01=-20000 -> x_o=32767, y_o=-32768, both saturated.
REQ-030 Full N=3 sweep:
- Emissions in order (0,1), (0,2), (1,2), vld_o 4 cycles apart.
- done_o coincident with the third vld_o; busy_o falls on that cycle.
- rd_addr_o sequence 0, 4, 1, 0, 8, 2, 4, 8, 5.
REQ-031 Assert rst for 1 cycle just after the 2nd vld_o -> all outputs 0 immediately, no third emission, and the next start re-emits (0,1) first.
REQ-032 Pulse start_i again 2 cycles into a sweep -> ignored; exactly 3 emissions and 1 done_o.
REQ-033 With JACOBI_PIVOT_SKIP_EN, SKIP_THRESH=4 and a_02=3 -> pair (0,2) not emitted, skip_cnt_o=1, and done_o at the same cycle as without the macro.
